rotate_share_arbiter: RTL

- Shares one registered 8-bit rotate-right datapath between two requesters.
- Each requester uses a valid/ready handshake; a single result port returns the rotated data tagged with the requester id.
- Round-robin arbitration keeps both requesters from starving; per-requester saturating counters record completed transactions for debug.
- Sits between two client blocks and the shared rotate resource, which becomes a one-stage pipeline with backpressure.

---
 rtl/rotate_share_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/rotate_share_arbiter.sv
// rotate_share_arbiter
//
// Shares one registered rotate-right datapath between two requesters.
// Each requester hands over an operand and a rotate amount through a
// valid/ready handshake. A round-robin arbiter picks the requester, and
// the rotated value lands in a single result register tagged with the
// requester id. The result register drains through res_valid/res_ready.
// Two saturating counters record how many results each requester has had
// consumed.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   reqN_valid, reqN_a, reqN_amt requester N operation (N = 0, 1)
//   reqN_ready                   requester N accepted this cycle
//   res_valid, res_data, res_id  result register contents
//   res_ready                    consumer takes the result this cycle
//   done_cnt0, done_cnt1         completed results per requester (saturating)

module rotate_share_arbiter #(
    parameter int DATA_W = 8,
    parameter int AMT_W  = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [AMT_W-1:0]  req0_amt,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [AMT_W-1:0]  req1_amt,
    output logic              req1_ready,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    output logic              res_id,
    input  logic              res_ready,
    output logic [CNT_W-1:0]  done_cnt0,
    output logic [CNT_W-1:0]  done_cnt1
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              res_valid_q, res_valid_d;
    logic [DATA_W-1:0] res_data_q,  res_data_d;
    logic              res_id_q,    res_id_d;
    logic              last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  cnt0_q, cnt0_d;
    logic [CNT_W-1:0]  cnt1_q, cnt1_d;

    logic              can_accept;
    logic              grant;
    logic              accept;
    logic              drain;
    logic [DATA_W-1:0] sel_a;
    logic [AMT_W-1:0]  sel_amt;
    logic [AMT_W-1:0]  src_idx;
    logic [DATA_W-1:0] rotated;

    // Arbitration: on contention the requester that did not win last time
    // gets the grant. When neither is valid the grant value is irrelevant
    // because both readies are qualified with their own valid.
    always_comb begin
        can_accept = !res_valid_q || res_ready;
        grant      = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = !last_grant_q;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
        req0_ready = can_accept && req0_valid && !grant;
        req1_ready = can_accept && req1_valid &&  grant;
        accept     = req0_ready || req1_ready;
        drain      = res_valid_q && res_ready;
    end

    // Rotate right: output bit i takes input bit (i + amt) mod DATA_W.
    // DATA_W is a power of two, so the AMT_W-bit add wraps naturally.
    always_comb begin
        sel_a   = grant ? req1_a   : req0_a;
        sel_amt = grant ? req1_amt : req0_amt;
        rotated = '0;
        src_idx = '0;
        for (int i = 0; i < DATA_W; i++) begin
            src_idx    = AMT_W'(i) + sel_amt;
            rotated[i] = sel_a[src_idx];
        end
    end

    // Result register and counters. A new accept overrides the drain-to-empty,
    // which gives back-to-back results without a bubble. The counters only
    // look at the result leaving the register, so they are independent of
    // whether a new result is loaded in the same cycle.
    always_comb begin
        res_valid_d  = res_valid_q;
        res_data_d   = res_data_q;
        res_id_d     = res_id_q;
        last_grant_d = last_grant_q;
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;

        if (accept) begin
            res_valid_d  = 1'b1;
            res_data_d   = rotated;
            res_id_d     = grant;
            last_grant_d = grant;
        end else if (drain) begin
            res_valid_d = 1'b0;
        end

        if (drain) begin
            if (!res_id_q && cnt0_q != CNT_MAX) begin
                cnt0_d = cnt0_q + CNT_W'(1);
            end
            if (res_id_q && cnt1_q != CNT_MAX) begin
                cnt1_d = cnt1_q + CNT_W'(1);
            end
        end
    end

    // last_grant resets to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_id_q     <= 1'b0;
            last_grant_q <= 1'b1;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            res_id_q     <= res_id_d;
            last_grant_q <= last_grant_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign done_cnt0 = cnt0_q;
    assign done_cnt1 = cnt1_q;

endmodule
